// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [0:0] ST_BOOT = BOOT;
    localparam logic [0:0] ST_RUN  = RUN;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small shift-register FIFO; entry 0 is always the head, so the head output is a plain register.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 64,
    localparam int unsigned CW   = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [CW-1:0] count_o,
    output logic [W-1:0]  head_o
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] level;

    // Pop shifts first, then push writes at the post-pop level, so a full FIFO can push and pop together.
    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        level = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else begin
            if (pop_i && cnt_q != '0) begin
                for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                    mem_d[i] = mem_q[i + 1];
                end
                level = cnt_q - CW'(1);
            end
            if (push_i && level < DEPTH_C) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (level == CW'(i)) begin
                        mem_d[i] = push_data_i;
                    end
                end
                level = level + CW'(1);
            end
            cnt_d = level;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited req/gnt issue, in-order response FIFO, redirect with discard.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int unsigned CW      = cnt_width(DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [0:0]    state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic          stale_q, stale_d;
    logic [31:0]   stale_addr_q, stale_addr_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;

    logic          run;
    logic          redir;
    logic          gnt_acc;
    logic          pending;
    logic          rsp_acc;
    logic          push;
    logic          pop;
    logic          credit_ok;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] tag_count;
    logic [63:0]   fifo_head_raw;
    logic [31:0]   tag_pc;
    entry_t        head;
    entry_t        push_entry;

    assign run       = (state_q == ST_RUN);
    assign redir     = run && redirect;
    assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_count}) < DEPTH_W;

    assign imem_req  = run && (stale_q || credit_ok);
    assign imem_addr = stale_q ? stale_addr_q : fpc_q;

    assign gnt_acc = imem_req && imem_gnt;
    assign pending = imem_req && !imem_gnt;
    assign rsp_acc = imem_rvalid && (tag_count != '0);
    assign push    = rsp_acc && (discard_q == '0) && !redir;
    assign pop     = instr_valid && instr_ready;

    assign push_entry = '{pc: tag_pc, instr: imem_rdata};
    assign head       = fifo_head_raw;

    assign instr_valid = (fifo_count != '0);
    assign instr       = instr_valid ? head.instr : NOP;
    assign instr_pc    = instr_valid ? head.pc : fpc_q;

    // A request still pending at redirect keeps its old address until granted;
    // fpc already holds the target, so that grant must not advance it.
    always_comb begin
        state_d      = (state_q == ST_BOOT) ? ST_RUN : state_q;
        fpc_d        = fpc_q;
        stale_d      = stale_q;
        stale_addr_d = stale_addr_q;
        if (redir) begin
            fpc_d = redirect_pc & 32'hFFFF_FFFC;
            if (pending) begin
                stale_d      = 1'b1;
                stale_addr_d = imem_addr;
            end else begin
                stale_d = 1'b0;
            end
        end else if (gnt_acc) begin
            if (stale_q) begin
                stale_d = 1'b0;
            end else begin
                fpc_d = fpc_q + 32'd4;
            end
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (gnt_acc && !rsp_acc) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!gnt_acc && rsp_acc) begin
            inflight_d = inflight_q - CW'(1);
        end
    end

    // Every request outstanding after a redirect (granted or still pending) is old-stream.
    always_comb begin
        discard_d = discard_q;
        if (redir) begin
            discard_d = inflight_d + (pending ? CW'(1) : CW'(0));
        end else if (rsp_acc && discard_q != '0) begin
            discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            fpc_q        <= RESET_PC;
            stale_q      <= 1'b0;
            stale_addr_q <= RESET_PC;
            inflight_q   <= '0;
            discard_q    <= '0;
        end else begin
            state_q      <= state_d;
            fpc_q        <= fpc_d;
            stale_q      <= stale_d;
            stale_addr_q <= stale_addr_d;
            inflight_q   <= inflight_d;
            discard_q    <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (64)
    ) u_instr_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redir),
        .count_o     (fifo_count),
        .head_o      (fifo_head_raw)
    );

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_tag_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (gnt_acc),
        .push_data_i (imem_addr),
        .pop_i       (rsp_acc),
        .flush_i     (1'b0),
        .count_o     (tag_count),
        .head_o      (tag_pc)
    );

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end. Produces the 32-bit instruction word and its PC for the combinational control unit and datapath.
- Consumes the control unit's redirect decision (pcsel) and the target address.
- Issues word requests to instruction memory over a req/gnt + rvalid protocol and buffers responses in a small in-order FIFO.
- Supplies a NOP whenever no valid instruction is present, so the decoder never sees garbage.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, FIFO entries and maximum in-flight requests; legal range 2..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  request valid, address phase.
- imem_addr  out  32  word-aligned fetch address.
- imem_gnt  in  1  address phase accepted this cycle.
- imem_rvalid  in  1  response valid. Responses arrive in order, at least 1 cycle after gnt.
- imem_rdata  in  32  instruction word, valid with rvalid.
- redirect  in  1  take a new PC (driven by pcsel).
- redirect_pc  in  32  redirect target (ALU result).
- instr_ready  in  1  downstream consumes the current instruction this cycle.
- instr_valid  out  1  instr/instr_pc hold a real fetched instruction.
- instr  out  32  instruction word, or NOP (32'h0000_0013) when instr_valid=0.
- instr_pc  out  32  PC of instr.

Behaviour:
- Reset (async assert, sync release):
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=NOP, instr_pc=RESET_PC.
  - FIFO empty, inflight=0, discard=0, state=BOOT.
- State machine:
  - BOOT: one idle cycle after reset release, no request. Goes to RUN unconditionally.
  - RUN: normal operation. There is no other state.
- Fetch PC register (fpc):
  - Increments by 4 on each gnt.
  - Wraps 32'hFFFF_FFFC -> 0, modulo 2^32.
- Issue rule: imem_req=1 in RUN when (inflight + fifo_count) < DEPTH. This is credit-based, so the FIFO can never overflow.
- Address-phase stability:
  - Once imem_req=1, imem_req and imem_addr stay stable until imem_gnt.
  - A pending request is never withdrawn, even on redirect.
- inflight counter: +1 on gnt, -1 on rvalid; both in one cycle leaves it unchanged.
- Response path:
  - If discard>0, the rvalid response is dropped and discard decrements.
  - Otherwise the response is pushed to the FIFO together with its PC. The PC is taken from an in-order PC tag queue of depth DEPTH.
- Output latency:
  - FIFO head is registered, so rvalid in cycle t gives instr_valid in cycle t+1.
  - Minimum fetch-to-issue latency: gnt t, rvalid t+1, instr_valid t+2.
- Consume: when instr_valid && instr_ready, the FIFO pops and the next entry appears the following cycle. There is no combinational path from rvalid to instr.
- instr_ready=0: head entry and outputs hold unchanged.
- Redirect (sampled every cycle in RUN):
  - The FIFO is flushed next cycle, so instr_valid=0 and instr=NOP.
  - fpc is loaded with {redirect_pc[31:2],2'b00}. Low bits are silently cleared; misalignment is not flagged.
  - discard is loaded with all requests in flight that belong to the old stream:
    - inflight, minus 1 if an rvalid this cycle was already discarded or consumed,
    - plus 1 if a gnt occurs this cycle, or if a request is still pending ungranted.
  - A pending ungranted old request completes normally and its response is discarded. The first new-stream request issues after that gnt.
  - The first request to the target can issue in the cycle after redirect.
- Simultaneous events:
  - redirect + rvalid: the response is always old-stream and is dropped.
  - redirect + consume: the consume is honoured (it was the branch/jump itself), then flush.
  - redirect + gnt: the granted request is counted into discard.
  - Back-to-back redirects: discard accumulates correctly, and the second target wins.
  - Push and pop in the same cycle with the FIFO full is legal.
- Reset mid-operation:
  - Everything returns to reset values immediately.
  - Late rvalid pulses after reset release are ignored while inflight=0. The bench must not generate them.

Decomposition:
- Package fetch_pkg:
  - NOP constant 32'h0000_0013.
  - State enum {BOOT, RUN}.
  - Entry struct {pc[31:0], instr[31:0]}.
  - Counter width function clog2(DEPTH+1).
- Sub-module fetch_fifo:
  - Parameterised DEPTH, sync push/pop/flush, count output, registered head.
  - Instantiated once for instruction entries. The PC tag queue reuses the same module.

Test Plan:
- Reset/boot: release rst_n, memory with gnt always 1 and rvalid 1 cycle later.
  - Cycle 0: req=0.
  - Cycle 1: req=1, addr=0x0.
  - instr_valid first seen in cycle 3 with pc=0x0, then pc=0x4, 0x8 on consecutive cycles with instr_ready=1.
  - Before that, instr=0x00000013.
- Backpressure: instr_ready=0 for 10 cycles.
  - At most DEPTH=2 grants occur, then req stays 0.
  - Outputs hold pc=0x0.
  - On release, order 0x0, 0x4, 0x8 with no loss or duplication.
- Redirect with in-flight traffic: 2 requests outstanding (0x8, 0xC), pulse redirect with redirect_pc=0x103.
  - Both old responses are dropped.
  - Next addr=0x100, next valid instr_pc=0x100.
- Redirect while a request is pending ungranted (gnt held 0 for 3 cycles on addr 0x10).
  - addr stays 0x10 until gnt, its response is discarded.
  - Then addr=0x200 for redirect_pc=0x200.
- Wrap and random stall: RESET_PC=0xFFFF_FFF8, random gnt/rvalid delays of 0..3 cycles.
  - PCs observed are 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4, ...
  - A scoreboard confirms the in-order instr/pc pairing.
- Async reset mid-stream: assert rst_n with 2 in flight and the FIFO full.
  - Outputs go to reset values within the same cycle, without waiting for a clock edge.
  - Normal boot sequence repeats after release.
